block_controller: RTL

Core-side endpoint of the dispatcher↔core block handshake. It accepts one thread block (start + block_id) from the GPU dispatcher, splits the block into warps, and launches each active warp with a lane mask. It tracks warp completion and raises `done`, holding it until the dispatcher pulses reset. One instance sits at the top of each core, between the dispatcher and the warp schedulers.

---
 rtl/block_controller_pkg.sv | 24 ++
 rtl/block_controller_if.sv | 36 +++
 rtl/block_controller_warp_mask_gen.sv | 25 ++
 rtl/block_controller.sv | 99 +++++++++
 4 files changed

// File: rtl/block_controller_pkg.sv
// Shared definitions for the block controller slice.
// Provides the controller state type and encodings, the default core geometry, and the
// thread-count clamp used when a block is accepted.
package block_controller_pkg;

    typedef logic [1:0] block_state_t;

    localparam block_state_t IDLE = 2'd0;
    localparam block_state_t RUN  = 2'd1;
    localparam block_state_t DONE = 2'd2;

    localparam int unsigned NUM_WARPS_DEFAULT        = 4;
    localparam int unsigned THREADS_PER_WARP_DEFAULT = 8;

    // Clamp the requested thread count to the core capacity. 9 bits because a full core may
    // hold 256 threads, one more than threads_per_block can express.
    function automatic logic [8:0] clamp_threads(input logic [7:0] threads,
                                                 input logic [8:0] capacity);
        logic [8:0] wide;
        wide = {1'b0, threads};
        return (wide > capacity) ? capacity : wide;
    endfunction

endpackage

// File: rtl/block_controller_if.sv
// Dispatcher and warp-scheduler signals of one core's block controller.
//   master: dispatcher/scheduler side, drives start, block_id, threads_per_block, warp_done.
//   slave:  block controller, drives done, cur_block_id, overflow, warp_start,
//           warp_thread_mask, warp_base_thread, busy_cycles.
interface block_controller_if
    import block_controller_pkg::*;
#(
    parameter int unsigned NUM_WARPS        = NUM_WARPS_DEFAULT,
    parameter int unsigned THREADS_PER_WARP = THREADS_PER_WARP_DEFAULT
);

    logic                                  start;
    logic [7:0]                            block_id;
    logic [7:0]                            threads_per_block;
    logic                                  done;
    logic [7:0]                            cur_block_id;
    logic                                  overflow;
    logic [NUM_WARPS-1:0]                  warp_start;
    logic [NUM_WARPS-1:0]                  warp_done;
    logic [NUM_WARPS*THREADS_PER_WARP-1:0] warp_thread_mask;
    logic [NUM_WARPS*8-1:0]                warp_base_thread;
    logic [15:0]                           busy_cycles;

    modport master (
        output start, block_id, threads_per_block, warp_done,
        input  done, cur_block_id, overflow, warp_start, warp_thread_mask,
               warp_base_thread, busy_cycles
    );

    modport slave (
        input  start, block_id, threads_per_block, warp_done,
        output done, cur_block_id, overflow, warp_start, warp_thread_mask,
               warp_base_thread, busy_cycles
    );

endinterface

// File: rtl/block_controller_warp_mask_gen.sv
// Combinational lane-mask generator for one warp slot.
//   eff:       effective (clamped) thread count of the block, 0..256.
//   lane_mask: lane l set iff WARP_INDEX*THREADS_PER_WARP + l < eff.
//   active:    warp holds at least one thread.
module block_controller_warp_mask_gen #(
    parameter int unsigned WARP_INDEX       = 0,
    parameter int unsigned THREADS_PER_WARP = 8
) (
    input  logic [8:0]                  eff,
    output logic [THREADS_PER_WARP-1:0] lane_mask,
    output logic                        active
);

    localparam logic [8:0] BASE = 9'(WARP_INDEX * THREADS_PER_WARP);

    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < THREADS_PER_WARP; l++) begin
            lane_mask[l] = (BASE + 9'(l)) < eff;
        end
    end

    assign active = BASE < eff;

endmodule

// File: rtl/block_controller.sv
// Core-side endpoint of the dispatcher/core block handshake.
// Accepts one block while start is high, launches each active warp with its lane mask,
// tracks warp completion and raises done, holding it until the dispatcher resets the core.
//   clk, reset: clock and synchronous active-high reset.
//   bus:        block_controller_if slave modport (dispatcher and warp-scheduler signals).
module block_controller
    import block_controller_pkg::*;
#(
    parameter int unsigned NUM_WARPS        = NUM_WARPS_DEFAULT,
    parameter int unsigned THREADS_PER_WARP = THREADS_PER_WARP_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    block_controller_if.slave bus
);

    localparam int unsigned LANES    = NUM_WARPS * THREADS_PER_WARP;
    localparam logic [8:0]  CAPACITY = 9'(LANES);

    block_state_t         state;
    logic [NUM_WARPS-1:0] active_mask;
    logic [NUM_WARPS-1:0] finished;
    logic [NUM_WARPS-1:0] active_c;
    logic [NUM_WARPS-1:0] completing;
    logic [NUM_WARPS-1:0] finished_c;
    logic [LANES-1:0]     mask_c;
    logic [8:0]           eff;

    assign eff = clamp_threads(bus.threads_per_block, CAPACITY);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        block_controller_warp_mask_gen #(
            .WARP_INDEX       (w),
            .THREADS_PER_WARP (THREADS_PER_WARP)
        ) u_mask_gen (
            .eff       (eff),
            .lane_mask (mask_c[w*THREADS_PER_WARP +: THREADS_PER_WARP]),
            .active    (active_c[w])
        );
        assign bus.warp_base_thread[w*8 +: 8] = 8'(w * THREADS_PER_WARP);
    end

    // warp_done only counts while that warp is launched; inactive slots never have warp_start.
    assign completing = bus.warp_start & bus.warp_done;
    assign finished_c = finished | completing;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            bus.done             <= 1'b0;
            bus.cur_block_id     <= 8'd0;
            bus.overflow         <= 1'b0;
            bus.warp_start       <= '0;
            bus.warp_thread_mask <= '0;
            bus.busy_cycles      <= 16'd0;
            finished             <= '0;
            active_mask          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.cur_block_id     <= bus.block_id;
                        bus.overflow         <= bus.overflow |
                                                ({1'b0, bus.threads_per_block} > CAPACITY);
                        bus.warp_thread_mask <= mask_c;
                        bus.warp_start       <= active_c;
                        active_mask          <= active_c;
                        finished             <= '0;
                        if (eff == 9'd0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.busy_cycles != 16'hFFFF) begin
                        bus.busy_cycles <= bus.busy_cycles + 16'd1;
                    end
                    bus.warp_start <= bus.warp_start & ~completing;
                    finished       <= finished_c;
                    // Include this edge's completions so done rises on the last warp_done edge.
                    if ((finished_c & active_mask) == active_mask) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    // Everything holds until reset.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
